airi5c_pcpi_arbiter: RTL and testbench

Shares the core's PCPI co-processor port between up to `NUM_SLAVES` custom-instruction units, such as the bit-reverse custom unit. It broadcasts each offloaded instruction to all slaves and locks onto the lowest-index slave that claims it. It returns that slave's registered result to the core. An instruction that no slave claims within `TIMEOUT` cycles is reported as illegal.

---
 rtl/airi5c_pcpi_arbiter_pkg.sv | 21 ++
 rtl/airi5c_pcpi_prio_enc.sv | 25 ++
 rtl/airi5c_pcpi_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_airi5c_pcpi_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/airi5c_pcpi_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | airi5c_pcpi_arbiter_pkg : shared PCPI arbiter constants and state codes   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package airi5c_pcpi_arbiter_pkg;

  localparam int XPR_LEN            = 32;
  localparam int DEFAULT_NUM_SLAVES = 4;
  localparam int DEFAULT_TIMEOUT    = 16;
  localparam int IDX_W              = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_DONE  = 2'd2,
    ST_TRAP  = 2'd3
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/airi5c_pcpi_prio_enc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | airi5c_pcpi_prio_enc : lowest-index-first priority encoder               |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module airi5c_pcpi_prio_enc
  import airi5c_pcpi_arbiter_pkg::*;
#(
  parameter int NUM_SLAVES = DEFAULT_NUM_SLAVES
) (
  input  logic [NUM_SLAVES-1:0] req,
  output logic                  any,
  output logic [IDX_W-1:0]      idx
);

  always_comb begin
    any = |req;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/airi5c_pcpi_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | airi5c_pcpi_arbiter : shares one PCPI port among up to 8 custom units.   |
// | Unclaimed-instruction trap enabled by `AIRI5C_PCPI_TIMEOUT_EN.            |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module airi5c_pcpi_arbiter
  import airi5c_pcpi_arbiter_pkg::*;
#(
  parameter int NUM_SLAVES = DEFAULT_NUM_SLAVES,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic                          pcpi_valid,
  input  logic [XPR_LEN-1:0]            pcpi_insn,
  input  logic [XPR_LEN-1:0]            pcpi_rs1,
  input  logic [XPR_LEN-1:0]            pcpi_rs2,
  input  logic [XPR_LEN-1:0]            pcpi_rs3,
  output logic                          pcpi_wr,
  output logic [XPR_LEN-1:0]            pcpi_rd,
  output logic [XPR_LEN-1:0]            pcpi_rd2,
  output logic                          pcpi_use_rd64,
  output logic                          pcpi_wait,
  output logic                          pcpi_ready,
  output logic                          pcpi_illegal,
  output logic [NUM_SLAVES-1:0]         s_valid,
  output logic [XPR_LEN-1:0]            s_insn,
  output logic [XPR_LEN-1:0]            s_rs1,
  output logic [XPR_LEN-1:0]            s_rs2,
  output logic [XPR_LEN-1:0]            s_rs3,
  input  logic [NUM_SLAVES-1:0]         s_wr,
  input  logic [NUM_SLAVES-1:0]         s_use_rd64,
  input  logic [NUM_SLAVES-1:0]         s_wait,
  input  logic [NUM_SLAVES-1:0]         s_ready,
  input  logic [XPR_LEN*NUM_SLAVES-1:0] s_rd,
  input  logic [XPR_LEN*NUM_SLAVES-1:0] s_rd2
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 8 || TIMEOUT < 1) begin : g_bad_params
  end

  arb_state_e          state;
  logic [IDX_W-1:0]    owner;
  logic [NUM_SLAVES-1:0] claim_req;
  logic                claim_any;
  logic [IDX_W-1:0]    claim_idx;
  logic [IDX_W-1:0]    cap_sel;
  logic [NUM_SLAVES-1:0] owner_oh;

  // Slave responses padded to 8 entries so a 3-bit index is always in range.
  logic [7:0]          ready_x;
  logic [7:0]          wr_x;
  logic [7:0]          u64_x;
  logic [XPR_LEN-1:0]  rd_x  [8];
  logic [XPR_LEN-1:0]  rd2_x [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_pad
    if (gi < NUM_SLAVES) begin : g_live
      assign ready_x[gi] = s_ready[gi];
      assign wr_x[gi]    = s_wr[gi];
      assign u64_x[gi]   = s_use_rd64[gi];
      assign rd_x[gi]    = s_rd[XPR_LEN*gi +: XPR_LEN];
      assign rd2_x[gi]   = s_rd2[XPR_LEN*gi +: XPR_LEN];
    end else begin : g_tie
      assign ready_x[gi] = 1'b0;
      assign wr_x[gi]    = 1'b0;
      assign u64_x[gi]   = 1'b0;
      assign rd_x[gi]    = '0;
      assign rd2_x[gi]   = '0;
    end
  end

  assign claim_req = (s_wait | s_ready) & {NUM_SLAVES{pcpi_valid}};

  airi5c_pcpi_prio_enc #(
    .NUM_SLAVES (NUM_SLAVES)
  ) u_prio_enc (
    .req (claim_req),
    .any (claim_any),
    .idx (claim_idx)
  );

  assign cap_sel = (state == ST_IDLE) ? claim_idx : owner;

  always_comb begin
    for (int i = 0; i < NUM_SLAVES; i++) owner_oh[i] = (owner == IDX_W'(i));
  end

  // Gated with nreset so every output is quiet while reset is held.
  assign s_insn = pcpi_insn & {XPR_LEN{nreset}};
  assign s_rs1  = pcpi_rs1  & {XPR_LEN{nreset}};
  assign s_rs2  = pcpi_rs2  & {XPR_LEN{nreset}};
  assign s_rs3  = pcpi_rs3  & {XPR_LEN{nreset}};

  always_comb begin
    s_valid   = '0;
    pcpi_wait = 1'b0;
    if (nreset) begin
      case (state)
        ST_IDLE: begin
          s_valid   = {NUM_SLAVES{pcpi_valid}};
          pcpi_wait = pcpi_valid;
        end
        ST_OWNED: begin
          s_valid   = owner_oh & {NUM_SLAVES{pcpi_valid}};
          pcpi_wait = 1'b1;
        end
        default: begin
          s_valid   = '0;
          pcpi_wait = 1'b0;
        end
      endcase
    end
  end

`ifdef AIRI5C_PCPI_TIMEOUT_EN
  localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0]             probe_cnt;
`endif

  // Result outputs double as the capture registers; they only hold data in DONE.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state         <= ST_IDLE;
      owner         <= '0;
      pcpi_ready    <= 1'b0;
      pcpi_illegal  <= 1'b0;
      pcpi_wr       <= 1'b0;
      pcpi_use_rd64 <= 1'b0;
      pcpi_rd       <= '0;
      pcpi_rd2      <= '0;
`ifdef AIRI5C_PCPI_TIMEOUT_EN
      probe_cnt     <= '0;
`endif
    end else begin
      pcpi_ready    <= 1'b0;
      pcpi_illegal  <= 1'b0;
      pcpi_wr       <= 1'b0;
      pcpi_use_rd64 <= 1'b0;
      pcpi_rd       <= '0;
      pcpi_rd2      <= '0;
      case (state)
        ST_IDLE: begin
          if (claim_any) begin
            owner <= claim_idx;
`ifdef AIRI5C_PCPI_TIMEOUT_EN
            probe_cnt <= '0;
`endif
            if (ready_x[cap_sel]) begin
              state         <= ST_DONE;
              pcpi_ready    <= 1'b1;
              pcpi_wr       <= wr_x[cap_sel];
              pcpi_use_rd64 <= u64_x[cap_sel];
              pcpi_rd       <= rd_x[cap_sel];
              pcpi_rd2      <= rd2_x[cap_sel];
            end else begin
              state <= ST_OWNED;
            end
          end
`ifdef AIRI5C_PCPI_TIMEOUT_EN
          else if (pcpi_valid) begin
            if (probe_cnt == CNT_LAST) begin
              probe_cnt    <= '0;
              state        <= ST_TRAP;
              pcpi_illegal <= 1'b1;
            end else begin
              probe_cnt <= probe_cnt + 1'b1;
            end
          end else begin
            probe_cnt <= '0;
          end
`endif
        end
        ST_OWNED: begin
          if (!pcpi_valid) begin
            state <= ST_IDLE;
          end else if (ready_x[cap_sel]) begin
            state         <= ST_DONE;
            pcpi_ready    <= 1'b1;
            pcpi_wr       <= wr_x[cap_sel];
            pcpi_use_rd64 <= u64_x[cap_sel];
            pcpi_rd       <= rd_x[cap_sel];
            pcpi_rd2      <= rd2_x[cap_sel];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_airi5c_pcpi_arbiter.sv
`default_nettype none
// Randomized bench for airi5c_pcpi_arbiter against a transaction-level model.
module tb_airi5c_pcpi_arbiter;

  localparam int NS = 4;
  localparam int TO = 16;
`ifdef AIRI5C_PCPI_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              nreset = 1'b0;
  logic              pcpi_valid = 1'b0;
  logic [31:0]       pcpi_insn = '0, pcpi_rs1 = '0, pcpi_rs2 = '0, pcpi_rs3 = '0;
  logic              pcpi_wr, pcpi_use_rd64, pcpi_wait, pcpi_ready, pcpi_illegal;
  logic [31:0]       pcpi_rd, pcpi_rd2;
  logic [NS-1:0]     s_valid;
  logic [31:0]       s_insn, s_rs1, s_rs2, s_rs3;
  logic [NS-1:0]     s_wr = '0, s_use_rd64 = '0, s_wait = '0, s_ready = '0;
  logic [32*NS-1:0]  s_rd = '0, s_rd2 = '0;

  int n_vec = 0;
  int n_err = 0;

  // Per-slave script: claims at cycle c, waits w cycles, then pulses ready.
  bit          sl_resp [NS];
  int          sl_c    [NS];
  int          sl_w    [NS];
  logic [31:0] sl_rd   [NS];
  logic [31:0] sl_rd2  [NS];
  bit          sl_wr   [NS];
  bit          sl_u64  [NS];

  always #5 clk = ~clk;

  airi5c_pcpi_arbiter #(.NUM_SLAVES(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .nreset(nreset), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_rs3(pcpi_rs3),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_rd2(pcpi_rd2),
    .pcpi_use_rd64(pcpi_use_rd64), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .pcpi_illegal(pcpi_illegal), .s_valid(s_valid), .s_insn(s_insn),
    .s_rs1(s_rs1), .s_rs2(s_rs2), .s_rs3(s_rs3), .s_wr(s_wr),
    .s_use_rd64(s_use_rd64), .s_wait(s_wait), .s_ready(s_ready),
    .s_rd(s_rd), .s_rd2(s_rd2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bitrev(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  task automatic clear_slaves();
    for (int i = 0; i < NS; i++) begin
      sl_resp[i] = 0; sl_c[i] = 0; sl_w[i] = 0;
      sl_rd[i] = '0; sl_rd2[i] = '0; sl_wr[i] = 0; sl_u64[i] = 0;
    end
  endtask

  task automatic set_slave(input int i, input int c, input int w, input logic [31:0] rd);
    sl_resp[i] = 1; sl_c[i] = c; sl_w[i] = w; sl_rd[i] = rd;
    sl_rd2[i] = ~rd; sl_wr[i] = 1; sl_u64[i] = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".s_valid"}, 64'(s_valid), 0);
    chk({tag, ".wait"},    64'(pcpi_wait), 0);
    chk({tag, ".ready"},   64'(pcpi_ready), 0);
    chk({tag, ".illegal"}, 64'(pcpi_illegal), 0);
    chk({tag, ".wr"},      64'(pcpi_wr), 0);
    chk({tag, ".rd"},      64'(pcpi_rd), 0);
    chk({tag, ".rd2"},     64'(pcpi_rd2), 0);
    chk({tag, ".u64"},     64'(pcpi_use_rd64), 0);
  endtask

  // One offload. The expected cycle-by-cycle behaviour follows from the
  // earliest claim cycle C and the lowest-index claimer W at that cycle.
  task automatic run_txn(input string name, input logic [31:0] rs1,
                         input bit want_abort, input bit rst_in_done);
    int C, W, R, last_valid, end_t, abort_at, kind;  // kind: 0 claim, 1 illegal, 2 hold
    logic [31:0] insn;
    bit v, done, trap, owned, probe;
    logic [NS-1:0] exp_sv;
    string tg;
    C = 1000; W = -1; abort_at = -1;
    for (int i = 0; i < NS; i++)
      if (sl_resp[i] && sl_c[i] < C) begin C = sl_c[i]; W = i; end
    if (TO_EN && (W < 0 || C > TO - 1)) begin
      kind = 1; R = TO; last_valid = TO;
    end else if (W < 0) begin
      kind = 2; R = -1; last_valid = TO + 7;
    end else begin
      kind = 0; R = C + sl_w[W] + 1; last_valid = R;
      if (want_abort && sl_w[W] >= 1) begin
        abort_at = C + 1 + int'($urandom % sl_w[W]);
        last_valid = abort_at - 1;
      end
    end
    end_t = ((abort_at >= 0) ? abort_at : last_valid) + 3;
    insn = $urandom;
    for (int i = 0; i < NS; i++) begin
      s_rd[32*i +: 32]  = sl_rd[i];
      s_rd2[32*i +: 32] = sl_rd2[i];
      s_wr[i]           = sl_wr[i];
      s_use_rd64[i]     = sl_u64[i];
    end
    for (int t = 0; t <= end_t; t++) begin
      @(negedge clk);
      v = (t <= last_valid);
      pcpi_valid = v; pcpi_insn = insn; pcpi_rs1 = rs1;
      pcpi_rs2 = ~rs1; pcpi_rs3 = insn ^ rs1;
      for (int i = 0; i < NS; i++) begin
        s_wait[i]  = v && sl_resp[i] && t >= sl_c[i] && t < sl_c[i] + sl_w[i];
        s_ready[i] = v && sl_resp[i] && t == sl_c[i] + sl_w[i];
      end
      #1;
      done  = (kind == 0) && (abort_at < 0) && (t == R);
      trap  = (kind == 1) && (t == R);
      owned = (kind == 0) && t > C && t < R && (abort_at < 0 || t <= abort_at);
      probe = !done && !trap && !owned;
      exp_sv = '0;
      if (probe && v) exp_sv = '1;
      if (owned && v) exp_sv[W] = 1'b1;
      tg = $sformatf("%s.t%0d", name, t);
      chk({tg, ".s_valid"}, 64'(s_valid), 64'(exp_sv));
      if (!done) chk({tg, ".wait"}, 64'(pcpi_wait), 64'(probe ? v : owned));
      chk({tg, ".ready"},   64'(pcpi_ready), 64'(done));
      chk({tg, ".illegal"}, 64'(pcpi_illegal), 64'(trap));
      chk({tg, ".rd"},      64'(pcpi_rd),  done ? 64'(sl_rd[W])  : 64'd0);
      chk({tg, ".rd2"},     64'(pcpi_rd2), done ? 64'(sl_rd2[W]) : 64'd0);
      chk({tg, ".wr"},      64'(pcpi_wr),       done ? 64'(sl_wr[W])  : 64'd0);
      chk({tg, ".u64"},     64'(pcpi_use_rd64), done ? 64'(sl_u64[W]) : 64'd0);
      if (t == 0) chk({tg, ".s_insn"}, 64'(s_insn), 64'(insn));
      if (t == 0) chk({tg, ".s_rs3"},  64'(s_rs3),  64'(insn ^ rs1));
      if (done && rst_in_done) begin
        #1 nreset = 1'b0;
        #1 check_all_zero({tg, ".rst_async"});
        @(negedge clk);
        pcpi_valid = 1'b0; s_wait = '0; s_ready = '0;
        nreset = 1'b1;
        #1 check_all_zero({tg, ".post_rst"});
        return;
      end
    end
    pcpi_valid = 1'b0; s_wait = '0; s_ready = '0;
  endtask

  initial begin
    #1 check_all_zero("reset");
    pcpi_valid = 1'b1;
    #1 check_all_zero("reset_valid");
    pcpi_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    nreset = 1'b1;

    // Bit-reverse unit on slave 2 answering in the first valid cycle.
    clear_slaves(); set_slave(2, 0, 0, bitrev(32'h0000_0001));
    run_txn("single", 32'h0000_0001, 0, 0);

    clear_slaves(); set_slave(1, 0, 3, 32'h1234_5678);
    run_txn("multi", $urandom, 0, 0);

    clear_slaves(); set_slave(0, 0, 2, 32'h0000_0005); set_slave(3, 0, 1, 32'hFFFF_FFFF);
    run_txn("simul", $urandom, 0, 0);

    clear_slaves();
    run_txn("unclaimed", $urandom, 0, 0);

    clear_slaves(); set_slave(1, 0, 4, 32'hDEAD_BEEF);
    run_txn("abort", $urandom, 1, 0);
    clear_slaves(); set_slave(3, 1, 1, 32'hCAFE_0001);
    run_txn("after_abort", $urandom, 0, 0);

    clear_slaves(); set_slave(2, 1, 1, 32'h0BAD_F00D);
    run_txn("rst_done", $urandom, 0, 1);
    clear_slaves(); set_slave(0, 0, 0, 32'h0000_00A5);
    run_txn("after_rst", $urandom, 0, 0);

    clear_slaves(); set_slave(1, TO - 1, 0, 32'h0000_0F0F);
    run_txn("edge_last", $urandom, 0, 0);
    clear_slaves(); set_slave(1, TO, 0, 32'h0000_F0F0);
    run_txn("edge_late", $urandom, 0, 0);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] r1;
      r1 = $urandom;
      clear_slaves();
      for (int i = 0; i < NS; i++) begin
        sl_resp[i] = ($urandom % 3) != 0;
        sl_c[i]    = (($urandom % 5) == 0) ? 13 + int'($urandom % 5) : int'($urandom % 4);
        sl_w[i]    = int'($urandom % 5);
        sl_rd[i]   = (i == 2) ? bitrev(r1) : $urandom;
        sl_rd2[i]  = $urandom;
        sl_wr[i]   = $urandom % 2;
        sl_u64[i]  = $urandom % 2;
      end
      run_txn($sformatf("rnd%0d", n), r1, ($urandom % 5) == 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
